// File: rtl/vx_mem_sched_pkg.sv
// Shared sizing helpers for the memory request scheduler.
// The request struct and pending-counter type depend on module parameters,
// so they are declared inside the module from these helpers.
package vx_mem_sched_pkg;

  // Index bits appended to the outgoing tag; a single requester still gets one bit.
  function automatic int calc_idx_bits(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  // Outgoing tag width: requester tag with the requester index below it.
  function automatic int calc_tag_out_width(input int tag_in_width, input int num_reqs);
    return tag_in_width + calc_idx_bits(num_reqs);
  endfunction

  // Pending counter must hold MAX_PENDING itself, hence the extra bit.
  function automatic int calc_pend_width(input int max_pending);
    return $clog2(max_pending) + 1;
  endfunction

endpackage

// File: rtl/vx_mem_req_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// pointer. The pointer moves past the winner only when enable is high.
module vx_rr_arbiter
  import vx_mem_sched_pkg::*;
#(
  parameter  int NUM_REQS = 4,
  localparam int IDX_BITS = calc_idx_bits(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                enable,
  output logic [NUM_REQS-1:0] grant,
  output logic [IDX_BITS-1:0] grant_idx
);

  logic [IDX_BITS-1:0] ptr_q;
  logic [IDX_BITS-1:0] cand;
  logic                found;

  // Scan from the pointer, wrapping, and take the first requester found.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      cand = IDX_BITS'((int'(ptr_q) + k) % NUM_REQS);
      if (!found && requests[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Pointer advances to the slot after the winner on an accepted grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ptr_q <= '0;
    else if (enable && found)
      ptr_q <= (grant_idx == IDX_BITS'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/vx_mem_req_sched.sv
// Memory request scheduler: shares one memory port among NUM_REQS requesters
// with round-robin arbitration, per-requester read credits and a single
// registered request stage. Responses route back by the index held in the
// low tag bits.
// Optional perf counters are built when VX_MEM_SCHED_PERF_EN is defined.
module vx_mem_req_sched
  import vx_mem_sched_pkg::*;
#(
  parameter  int NUM_REQS      = 4,
  parameter  int ADDR_WIDTH    = 26,
  parameter  int DATA_WIDTH    = 512,
  parameter  int TAG_IN_WIDTH  = 8,
  parameter  int MAX_PENDING   = 8,
  localparam int IDX_BITS      = calc_idx_bits(NUM_REQS),
  localparam int TAG_OUT_WIDTH = calc_tag_out_width(TAG_IN_WIDTH, NUM_REQS),
  localparam int BE_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_REQS-1:0]                      req_valid_in,
  input  logic [NUM_REQS-1:0]                      req_rw_in,
  input  logic [NUM_REQS-1:0][BE_WIDTH-1:0]        req_byteen_in,
  input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]      req_addr_in,
  input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]      req_data_in,
  input  logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]    req_tag_in,
  output logic [NUM_REQS-1:0]                      req_ready_in,
  output logic                                     mem_req_valid,
  output logic                                     mem_req_rw,
  output logic [BE_WIDTH-1:0]                      mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]                    mem_req_addr,
  output logic [DATA_WIDTH-1:0]                    mem_req_data,
  output logic [TAG_OUT_WIDTH-1:0]                 mem_req_tag,
  input  logic                                     mem_req_ready,
  input  logic                                     mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]                    mem_rsp_data,
  input  logic [TAG_OUT_WIDTH-1:0]                 mem_rsp_tag,
  output logic                                     mem_rsp_ready,
  output logic [NUM_REQS-1:0]                      rsp_valid_out,
  output logic [NUM_REQS-1:0][DATA_WIDTH-1:0]      rsp_data_out,
  output logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]    rsp_tag_out,
  input  logic [NUM_REQS-1:0]                      rsp_ready_out,
  output logic                                     busy
`ifdef VX_MEM_SCHED_PERF_EN
  ,
  output logic [31:0]                              perf_req_stalls,
  output logic [31:0]                              perf_credit_stalls,
  output logic [31:0]                              perf_reads
`endif
);

  localparam int PCW = calc_pend_width(MAX_PENDING);

  typedef logic [PCW-1:0] pend_t;

  typedef struct packed {
    logic                     rw;
    logic [BE_WIDTH-1:0]      byteen;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]    data;
    logic [TAG_OUT_WIDTH-1:0] tag;
  } mem_req_t;

  localparam pend_t PEND_MAX = pend_t'(MAX_PENDING);

  pend_t [NUM_REQS-1:0] pending_q;
  logic  [NUM_REQS-1:0] eligible;
  logic  [NUM_REQS-1:0] grant;
  logic  [NUM_REQS-1:0] rsp_fire;
  logic  [IDX_BITS-1:0] grant_idx;
  logic  [IDX_BITS-1:0] rsp_idx;
  logic                 idx_ok;
  logic                 stage_free;
  logic                 accept;
  logic                 stage_vld_q;
  mem_req_t             stage_q;
  mem_req_t             stage_d;

  // ---------------- request side ----------------

  // Reads need a free credit; writes are always eligible.
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++)
      eligible[i] = req_valid_in[i] && (req_rw_in[i] || (pending_q[i] < PEND_MAX));
  end

  assign stage_free = !stage_vld_q || mem_req_ready;
  assign accept     = |grant && stage_free;

  vx_rr_arbiter #(
    .NUM_REQS (NUM_REQS)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .requests  (eligible),
    .enable    (stage_free),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready_in = grant & {NUM_REQS{stage_free}};

  // Select the granted requester's fields and append its index to the tag.
  always_comb begin
    stage_d        = '0;
    stage_d.rw     = req_rw_in[grant_idx];
    stage_d.byteen = req_byteen_in[grant_idx];
    stage_d.addr   = req_addr_in[grant_idx];
    stage_d.data   = req_data_in[grant_idx];
    stage_d.tag    = {req_tag_in[grant_idx], grant_idx};
  end

  // Output stage: load on accept, drain on fire, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_vld_q <= 1'b0;
      stage_q     <= '0;
    end else if (accept) begin
      stage_vld_q <= 1'b1;
      stage_q     <= stage_d;
    end else if (mem_req_ready) begin
      stage_vld_q <= 1'b0;
    end
  end

  assign mem_req_valid  = stage_vld_q;
  assign mem_req_rw     = stage_q.rw;
  assign mem_req_byteen = stage_q.byteen;
  assign mem_req_addr   = stage_q.addr;
  assign mem_req_data   = stage_q.data;
  assign mem_req_tag    = stage_q.tag;

  // ---------------- response side ----------------

  assign rsp_idx       = mem_rsp_tag[IDX_BITS-1:0];
  assign idx_ok        = ({1'b0, rsp_idx} < (IDX_BITS + 1)'(NUM_REQS));
  // An out-of-range index is swallowed so the memory side never stalls on it.
  assign mem_rsp_ready = idx_ok ? rsp_ready_out[rsp_idx] : 1'b1;

  for (genvar j = 0; j < NUM_REQS; j++) begin : g_rsp
    assign rsp_valid_out[j] = mem_rsp_valid && idx_ok && (rsp_idx == IDX_BITS'(j));
    assign rsp_data_out[j]  = mem_rsp_data;
    assign rsp_tag_out[j]   = mem_rsp_tag[TAG_OUT_WIDTH-1:IDX_BITS];
    assign rsp_fire[j]      = rsp_valid_out[j] && rsp_ready_out[j];

    logic rd_inc;
    assign rd_inc = accept && grant[j] && !req_rw_in[j];

    // Credit count: up on read accept, down on routed response, hold on both.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        pending_q[j] <= '0;
      else if (rd_inc && !rsp_fire[j])
        pending_q[j] <= pending_q[j] + 1'b1;
      else if (!rd_inc && rsp_fire[j] && (pending_q[j] != '0))
        pending_q[j] <= pending_q[j] - 1'b1;
    end

    // A response with no outstanding read is a protocol error upstream.
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
      !(rsp_fire[j] && !rd_inc && (pending_q[j] == '0)));
  end

  a_rsp_idx_range: assert property (@(posedge clk) disable iff (!reset)
    !(mem_rsp_valid && !idx_ok));

  // Busy while the stage holds a request or any read is still owed.
  always_comb begin
    busy = stage_vld_q;
    for (int i = 0; i < NUM_REQS; i++)
      if (pending_q[i] != '0) busy = 1'b1;
  end

`ifdef VX_MEM_SCHED_PERF_EN
  logic credit_block;

  // Some read is held back only because its requester is out of credits.
  always_comb begin
    credit_block = 1'b0;
    for (int i = 0; i < NUM_REQS; i++)
      if (req_valid_in[i] && !req_rw_in[i] && (pending_q[i] == PEND_MAX))
        credit_block = 1'b1;
  end

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_req_stalls    <= '0;
      perf_credit_stalls <= '0;
      perf_reads         <= '0;
    end else begin
      if (|req_valid_in && !accept) perf_req_stalls    <= perf_req_stalls + 32'd1;
      if (credit_block)             perf_credit_stalls <= perf_credit_stalls + 32'd1;
      if (accept && !stage_d.rw)    perf_reads         <= perf_reads + 32'd1;
    end
  end
`endif

endmodule
